uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Synchronous 16-entry FIFO that buffers received UART character records between the receiver state machine and the register-read logic. Records are pushed by the receiver and popped on a receive-buffer read. The block reports:
- current occupancy,
- sticky overrun and underrun flags,
- a summary flag that is set if any stored record carries a parity or framing error.

The head record is presented on `data_out` at all times (show-ahead).

## Interface
- `fifo_width`, default 11: record width in bits. Bits [1:0] of a record are error flags (bit 1 parity error, bit 0 framing error). Upper bits carry the character.
- `fifo_depth`, fixed 16: number of entries.
- `fifo_counter_w`, default 5: width of `count`.
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `wb_rst_i`, input, 1: synchronous, active-high reset.
- `data_in`, input, `fifo_width`: record to store.
- `push`, input, 1: write `data_in` this cycle.
- `pop`, input, 1: discard the head record this cycle.
- `fifo_reset`, input, 1: synchronous flush. Same effect as `wb_rst_i`.
- `reset_status`, input, 1: clears `overrun` and `underrun` only.
- `data_out`, output, `fifo_width`: head record. Combinational from storage.
- `count`, output, `fifo_counter_w`: occupancy, 0..16.
- `overrun`, output, 1: sticky. A push was attempted while full.
- `underrun`, output, 1: sticky. A pop was attempted while empty.
- `error_bit`, output, 1: OR of bits [1:0] over all occupied entries.

## Operation
- Storage is a 16×`fifo_width` circular array with 4-bit `top` (write) and `bottom` (read) pointers. Both pointers wrap 15→0.
- Priority per edge is `wb_rst_i` > `fifo_reset` > normal operation. `reset_status` is applied in the same cycle as normal operation.
- Reset or flush:
  - pointers = 0, `count` = 0;
  - all entries cleared to 0, so `data_out` = 0;
  - `overrun` = 0, `underrun` = 0, `error_bit` = 0.
- Push only:
  - not full: write at `top`, increment `top` and `count`;
  - full (`count` = 16): drop the data, set `overrun`, leave pointers and count unchanged.
- Pop only:
  - not empty: increment `bottom`, decrement `count`;
  - empty: set `underrun`, leave everything else unchanged.
- Push and pop together:
  - 1 ≤ `count` ≤ 16: write at `top` and advance both pointers. `count` is unchanged. No flag is set, including when full.
  - `count` = 0: treat as push only. `count` becomes 1, `underrun` is not set.
- `reset_status` = 1: `overrun` and `underrun` go to 0 on that edge. A set condition in the same cycle wins, so the flag stays 1.
- `error_bit` is recomputed from occupied entries only.
  - Popping the only erroneous entry clears it.
  - Entries outside the occupied window never contribute.
- `data_out` = `mem[bottom]`. Its value is undefined-by-use when `count` = 0, but it is never X: it holds the last written or cleared content.

## Timing
- Push at edge N: `count`, `error_bit` and (if the FIFO was empty) `data_out` reflect the new record after edge N. There is no bypass within the same cycle.
- Pop at edge N: `data_out` shows the next record after edge N.
- `overrun` and `underrun` assert on the edge of the offending request and hold until `reset_status`, `fifo_reset` or `wb_rst_i`.
- One operation per cycle. Back-to-back pushes and pops at full clock rate are supported.
- Reset mid-stream discards all content in one cycle. A push in the same cycle as reset or flush is ignored.

## Test plan
- Reset, then idle:
  - `count` = 0, `data_out` = 0, `overrun` = `underrun` = `error_bit` = 0.
- Push 0x004, 0x008, 0x00C on consecutive cycles, then pop 3 times:
  - `count` goes 1, 2, 3, then 2, 1, 0;
  - `data_out` sequence is 0x004, 0x008, 0x00C.
- Push 16 records with values 0x010·i, then a 17th (0x7FC):
  - `count` = 16, `overrun` = 1;
  - 16 pops return the original 16 records in order, and 0x7FC never appears;
  - pulse `reset_status` → `overrun` = 0.
- Pop on an empty FIFO:
  - `underrun` = 1, `count` stays 0;
  - simultaneous push+pop on empty → `count` = 1, `underrun` unchanged;
  - push+pop on a full FIFO → `count` stays 16, no `overrun`.
- Push 0x101 (framing error) then 0x100:
  - `error_bit` = 1;
  - pop once → `error_bit` = 0.
- Fill with 20 pushes and pops interleaved to wrap the pointers, then assert `fifo_reset`:
  - ordering is preserved across the 15→0 wrap;
  - after the flush, `count` = 0 and all flags are 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: 16-entry show-ahead buffer of character records
// with occupancy, sticky overrun/underrun and a stored-error summary.
module uart_rx_fifo #(
    parameter int fifo_width     = 11,
    parameter int fifo_depth     = 16,
    parameter int fifo_counter_w = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic [fifo_width-1:0]     data_in,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      fifo_reset,
    input  logic                      reset_status,
    output logic [fifo_width-1:0]     data_out,
    output logic [fifo_counter_w-1:0] count,
    output logic                      overrun,
    output logic                      underrun,
    output logic                      error_bit
);

    localparam int PTR_W = 4;
    localparam logic [fifo_counter_w-1:0] FULL = fifo_counter_w'(fifo_depth);

    logic [fifo_width-1:0]     mem_q [fifo_depth];
    logic [PTR_W-1:0]          top_q, top_d;
    logic [PTR_W-1:0]          bottom_q, bottom_d;
    logic [fifo_counter_w-1:0] count_q, count_d;
    logic                      overrun_q, overrun_d;
    logic                      underrun_q, underrun_d;
    logic                      we;
    logic                      is_full, is_empty;
    logic [PTR_W-1:0]          off;
    logic                      err;

    assign is_full  = (count_q == FULL);
    assign is_empty = (count_q == '0);

    // Next-state for pointers, occupancy and sticky flags
    always_comb begin
        we         = 1'b0;
        top_d      = top_q;
        bottom_d   = bottom_q;
        count_d    = count_q;
        overrun_d  = reset_status ? 1'b0 : overrun_q;
        underrun_d = reset_status ? 1'b0 : underrun_q;
        unique case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    overrun_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    top_d   = top_q + 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    underrun_d = 1'b1;
                end else begin
                    bottom_d = bottom_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end
            end
            2'b11: begin
                we    = 1'b1;
                top_d = top_q + 1'b1;
                if (is_empty) begin
                    count_d = count_q + 1'b1;
                end else begin
                    bottom_d = bottom_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State update; reset and flush both wipe storage and flags
    always_ff @(posedge clk) begin
        if (wb_rst_i || fifo_reset) begin
            top_q      <= '0;
            bottom_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            for (int i = 0; i < fifo_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            top_q      <= top_d;
            bottom_q   <= bottom_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            if (we) begin
                mem_q[top_q] <= data_in;
            end
        end
    end

    // Error summary over the occupied window only
    always_comb begin
        err = 1'b0;
        off = '0;
        for (int i = 0; i < fifo_depth; i++) begin
            off = PTR_W'(i) - bottom_q;
            if (fifo_counter_w'(off) < count_q) begin
                err = err | (|mem_q[i][1:0]);
            end
        end
    end

    assign data_out  = mem_q[bottom_q];
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;
    assign error_bit = err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based model.
// Directed test-plan steps followed by a randomized phase.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic [10:0] data_in = '0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        fifo_reset = 1'b0;
    logic        reset_status = 1'b0;
    logic [10:0] data_out;
    logic [4:0]  count;
    logic        overrun;
    logic        underrun;
    logic        error_bit;

    int checks = 0;
    int failures = 0;

    logic [10:0] q[$];
    logic        m_ov = 1'b0;
    logic        m_un = 1'b0;
    logic        dout_zero = 1'b1;

    uart_rx_fifo dut (
        .clk(clk),
        .wb_rst_i(wb_rst_i),
        .data_in(data_in),
        .push(push),
        .pop(pop),
        .fifo_reset(fifo_reset),
        .reset_status(reset_status),
        .data_out(data_out),
        .count(count),
        .overrun(overrun),
        .underrun(underrun),
        .error_bit(error_bit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err();
        logic e = 1'b0;
        foreach (q[i]) e = e | (|q[i][1:0]);
        return e;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".count"}, int'(count), q.size());
        chk({tag, ".overrun"}, int'(overrun), int'(m_ov));
        chk({tag, ".underrun"}, int'(underrun), int'(m_un));
        chk({tag, ".error_bit"}, int'(error_bit), int'(model_err()));
        if (q.size() != 0)
            chk({tag, ".data_out"}, int'(data_out), int'(q[0]));
        else if (dout_zero)
            chk({tag, ".data_out"}, int'(data_out), 0);
    endtask

    // One clock: drive, edge, update model, check 1 time unit later
    task automatic step(input string tag, input logic ps, input logic pp,
                        input logic [10:0] d, input logic fr,
                        input logic rs, input logic rst);
        logic full, empty, ov_set, un_set;
        push = ps;
        pop = pp;
        data_in = d;
        fifo_reset = fr;
        reset_status = rs;
        wb_rst_i = rst;
        @(posedge clk);
        if (rst || fr) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            dout_zero = 1'b1;
        end else begin
            full = (q.size() == 16);
            empty = (q.size() == 0);
            ov_set = ps && !pp && full;
            un_set = pp && !ps && empty;
            if (pp && !empty) void'(q.pop_front());
            if (ps && !(full && !pp)) begin
                q.push_back(d);
                dout_zero = 1'b0;
            end
            if (rs) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
            m_ov = m_ov | ov_set;
            m_un = m_un | un_set;
        end
        #1;
        push = 1'b0;
        pop = 1'b0;
        fifo_reset = 1'b0;
        reset_status = 1'b0;
        wb_rst_i = 1'b0;
        check_all(tag);
    endtask

    initial begin
        @(posedge clk);
        #1;
        step("reset", 0, 0, 11'h0, 0, 0, 1);
        step("idle", 0, 0, 11'h0, 0, 0, 0);

        step("p004", 1, 0, 11'h004, 0, 0, 0);
        step("p008", 1, 0, 11'h008, 0, 0, 0);
        step("p00C", 1, 0, 11'h00C, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("pop3", 0, 1, 11'h0, 0, 0, 0);

        for (int i = 0; i < 16; i++)
            step("fill", 1, 0, 11'(16 * i), 0, 0, 0);
        step("p17", 1, 0, 11'h7FC, 0, 0, 0);
        for (int i = 0; i < 16; i++) step("drain", 0, 1, 11'h0, 0, 0, 0);
        step("rstat", 0, 0, 11'h0, 0, 1, 0);

        step("pop_empty", 0, 1, 11'h0, 0, 0, 0);
        step("pp_empty", 1, 1, 11'h123, 0, 0, 0);
        for (int i = 0; i < 15; i++) step("fill2", 1, 0, 11'(i * 8 + 3), 0, 0, 0);
        step("pp_full", 1, 1, 11'h2A8, 0, 0, 0);
        step("rst_mid", 1, 0, 11'h155, 0, 0, 1);

        step("p101", 1, 0, 11'h101, 0, 0, 0);
        step("p100", 1, 0, 11'h100, 0, 0, 0);
        step("pop_err", 0, 1, 11'h0, 0, 0, 0);
        step("pop_last", 0, 1, 11'h0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            step("wrap_push", 1, 0, 11'(i * 20 + 4), 0, 0, 0);
            step("wrap_pp", 1, 1, 11'(i * 20 + 8), 0, 0, 0);
            step("wrap_pop", 0, 1, 11'h0, 0, 0, 0);
        end
        for (int i = 0; i < 10; i++) step("wrap_fill", 1, 0, 11'(i + 1), 0, 0, 0);
        step("flush", 1, 0, 11'h3FF, 1, 0, 0);
        step("after_flush", 0, 0, 11'h0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic ps, pp, rs, fr;
            int bias;
            bias = (i / 50) % 2;
            ps = ($urandom_range(0, 99) < (bias ? 70 : 35));
            pp = ($urandom_range(0, 99) < (bias ? 35 : 70));
            rs = ($urandom_range(0, 19) == 0);
            fr = ($urandom_range(0, 99) == 0);
            step("rand", ps, pp, 11'($urandom), fr, rs, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
